// File: rtl/memwrite_checker_pkg.sv
// rtl/memwrite_checker_pkg.sv - shared state encoding and width helper for the store checker
package memwrite_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_e;

    // Index width that never collapses to zero bits for tiny tables.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/memwrite_checker_exp_table.sv
// rtl/memwrite_checker_exp_table.sv - expected (address, data) register file, sync write / async read
module memwrite_checker_exp_table #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int IW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IW-1:0]    widx,
    input  logic [WIDTH-1:0] wadr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IW-1:0]    ridx,
    output logic [WIDTH-1:0] radr,
    output logic [WIDTH-1:0] rdata
);

    logic [2*WIDTH-1:0] mem_q [DEPTH];

    // Table contents survive reset so a run can be restarted without reloading.
    always_ff @(posedge clk) begin
        if (we && (int'(widx) < DEPTH)) begin
            mem_q[widx] <= {wadr, wdata};
        end
    end

    assign {radr, rdata} = (int'(ridx) < DEPTH) ? mem_q[ridx] : '0;

endmodule

// File: rtl/memwrite_checker.sv
// rtl/memwrite_checker.sv - in-order store-stream checker against a programmable expected table
module memwrite_checker
    import memwrite_checker_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 8,
    parameter int TIMEOUT      = 4096,
    parameter int CHECK_ADR    = 1,
    parameter int STOP_ON_FAIL = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cfg_we,
    input  logic [idx_w(DEPTH)-1:0]     cfg_idx,
    input  logic [WIDTH-1:0]            cfg_adr,
    input  logic [WIDTH-1:0]            cfg_data,
    input  logic [idx_w(DEPTH+1)-1:0]   cfg_count,
    input  logic                        start,
    input  logic                        memwrite,
    input  logic [WIDTH-1:0]            adr,
    input  logic [WIDTH-1:0]            writedata,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic                        fail,
    output logic                        timeout,
    output logic [idx_w(DEPTH)-1:0]     fail_idx,
    output logic [idx_w(DEPTH+1)-1:0]   err_count,
    output logic [idx_w(DEPTH+1)-1:0]   store_count
);

    localparam int IW = idx_w(DEPTH);
    localparam int CW = idx_w(DEPTH + 1);
    localparam int TW = idx_w(TIMEOUT);

    state_e           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d, fail_idx_q, fail_idx_d;
    logic [CW-1:0]    count_q, count_d, err_q, err_d, stores_q, stores_d;
    logic [TW-1:0]    cyc_q, cyc_d;
    logic             timeout_q, timeout_d;
    logic [WIDTH-1:0] exp_adr, exp_data;
    logic [CW-1:0]    count_in;
    logic             tbl_we, match, last;

    assign tbl_we = cfg_we && (state_q == ST_IDLE);

    memwrite_checker_exp_table #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_table (
        .clk   (clk),
        .we    (tbl_we),
        .widx  (cfg_idx),
        .wadr  (cfg_adr),
        .wdata (cfg_data),
        .ridx  (ptr_q),
        .radr  (exp_adr),
        .rdata (exp_data)
    );

    assign count_in = (int'(cfg_count) > DEPTH) ? CW'(DEPTH) : cfg_count;
    // An X/Z on the bus leaves match unknown, which the if() below treats as a mismatch.
    assign match    = (writedata == exp_data) && ((CHECK_ADR == 0) || (adr == exp_adr));
    assign last     = (int'(ptr_q) == int'(count_q) - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            fail_idx_q <= '0;
            count_q    <= '0;
            err_q      <= '0;
            stores_q   <= '0;
            cyc_q      <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            fail_idx_q <= fail_idx_d;
            count_q    <= count_d;
            err_q      <= err_d;
            stores_q   <= stores_d;
            cyc_q      <= cyc_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        fail_idx_d = fail_idx_q;
        count_d    = count_q;
        err_d      = err_q;
        stores_d   = stores_q;
        cyc_d      = cyc_q;
        timeout_d  = timeout_q;
        case (state_q)
            ST_RUN: begin
                cyc_d = cyc_q + 1'b1;
                if (memwrite) begin
                    stores_d = stores_q + 1'b1;
                    if (match) begin
                        ptr_d = ptr_q + 1'b1;
                        if (last) state_d = (err_q == '0) ? ST_PASS : ST_FAIL;
                    end else if (STOP_ON_FAIL != 0) begin
                        fail_idx_d = ptr_q;
                        err_d      = CW'(1);
                        state_d    = ST_FAIL;
                    end else begin
                        if (err_q == '0) fail_idx_d = ptr_q;
                        err_d = err_q + 1'b1;
                        ptr_d = ptr_q + 1'b1;
                        if (last) state_d = ST_FAIL;
                    end
                end
                // A store that finishes the run in the last allowed cycle wins over the timeout.
                if ((state_d == ST_RUN) && (cyc_q == TW'(TIMEOUT - 1))) begin
                    timeout_d = 1'b1;
                    state_d   = ST_FAIL;
                end
            end
            default: begin
                if (start) begin
                    count_d    = count_in;
                    ptr_d      = '0;
                    cyc_d      = '0;
                    err_d      = '0;
                    stores_d   = '0;
                    fail_idx_d = '0;
                    timeout_d  = 1'b0;
                    state_d    = (count_in == '0) ? ST_PASS : ST_RUN;
                end
            end
        endcase
    end

    always_comb begin
        busy        = (state_q == ST_RUN);
        pass        = (state_q == ST_PASS);
        fail        = (state_q == ST_FAIL);
        done        = (state_q == ST_PASS) || (state_q == ST_FAIL);
        timeout     = timeout_q;
        fail_idx    = fail_idx_q;
        err_count   = err_q;
        store_count = stores_q;
    end

endmodule
